// File: rtl/mmc_cmd_tx.sv
// mmc_cmd_tx: host-side MMC/SD command transmitter. Divides clk into
// mmc_clk and shifts out one 48-bit CMD frame (start, dir, index, arg,
// CRC7, end) per accepted start, then holds NCC idle mmc_clk periods.
// Ports: clk, reset_i (async, active-high); start, cmd_index[5:0],
// cmd_arg[31:0] request; busy, done status; mmc_clk, mmc_cmd_o,
// mmc_cmd_oe card side; frame_o[47:0] last frame sent.
// Option: define MMC_CMD_TX_CRC_INJECT_EN to add crc_xor[6:0], which is
// XORed into the transmitted CRC7 field.
module mmc_cmd_tx #(
  parameter int CLK_DIV = 4,
  parameter int NCC     = 8
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
`ifdef MMC_CMD_TX_CRC_INJECT_EN
  input  logic [6:0]  crc_xor,
`endif
  output logic        busy,
  output logic        done,
  output logic        mmc_clk,
  output logic        mmc_cmd_o,
  output logic        mmc_cmd_oe,
  output logic [47:0] frame_o
);

  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GW   = (NCC > 1) ? $clog2(NCC) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [DW-1:0] div_q, div_d;
  logic          clk_q, clk_d;
  logic [1:0]    st_q, st_d;
  logic [47:0]   fr_q, fr_d;
  logic [47:0]   frame_q, frame_d;
  logic [5:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cmd_q, cmd_d;
  logic          oe_q, oe_d;

  logic          wrap;
  logic          fall;
  logic [39:0]   hdr;
  logic [6:0]    crc;
  logic [47:0]   frm;

  // Bitwise CRC7, polynomial x^7+x^3+1, zero seed, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign wrap = (div_q == DW'(HALF - 1));
  // Fall tick: the cycle whose closing edge takes mmc_clk 1->0.
  assign fall = wrap & clk_q;

  assign hdr = {2'b01, cmd_index, cmd_arg};
`ifdef MMC_CMD_TX_CRC_INJECT_EN
  assign crc = crc7(hdr) ^ crc_xor;
`else
  assign crc = crc7(hdr);
`endif
  assign frm = {hdr, crc, 1'b1};

  always_comb begin
    div_d   = wrap ? '0 : div_q + DW'(1);
    clk_d   = wrap ? ~clk_q : clk_q;
    st_d    = st_q;
    fr_d    = fr_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cmd_d   = cmd_q;
    oe_d    = oe_q;
    unique case (st_q)
      S_IDLE: begin
        // The done cycle already sits in IDLE; a start there is dropped.
        if (start && !done_q) begin
          fr_d   = frm;
          busy_d = 1'b1;
          st_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fall) begin
          cmd_d = fr_q[47];
          oe_d  = 1'b1;
          bit_d = 6'd47;
          st_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (fall) begin
          if (bit_q == 6'd0) begin
            oe_d    = 1'b0;
            cmd_d   = 1'b1;
            frame_d = fr_q;
            gap_d   = '0;
            st_d    = S_GAP;
          end else begin
            bit_d = bit_q - 6'd1;
            cmd_d = fr_q[bit_q - 6'd1];
          end
        end
      end
      S_GAP: begin
        if (fall) begin
          if (gap_q == GW'(NCC - 1)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            st_d   = S_IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      div_q   <= '0;
      clk_q   <= 1'b0;
      st_q    <= S_IDLE;
      fr_q    <= '0;
      frame_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cmd_q   <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      clk_q   <= clk_d;
      st_q    <= st_d;
      fr_q    <= fr_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cmd_q   <= cmd_d;
      oe_q    <= oe_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mmc_clk    = clk_q;
  assign mmc_cmd_o  = cmd_q;
  assign mmc_cmd_oe = oe_q;
  assign frame_o    = frame_q;

endmodule

// File: tb/tb_mmc_cmd_tx.sv
// tb_mmc_cmd_tx: directed table-driven bench for mmc_cmd_tx.
// Frames are captured on mmc_clk rising edges and compared to constants.
module tb_mmc_cmd_tx;

  localparam int CLK_DIV = 4;
  localparam int NCC     = 8;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy, done, mmc_clk, mmc_cmd_o, mmc_cmd_oe;
  logic [47:0] frame_o;
`ifdef MMC_CMD_TX_CRC_INJECT_EN
  logic [6:0]  crc_xor = 7'h00;
`endif

  mmc_cmd_tx #(.CLK_DIV(CLK_DIV), .NCC(NCC)) dut (
    .clk(clk),
    .reset_i(reset_i),
    .start(start),
    .cmd_index(cmd_index),
    .cmd_arg(cmd_arg),
`ifdef MMC_CMD_TX_CRC_INJECT_EN
    .crc_xor(crc_xor),
`endif
    .busy(busy),
    .done(done),
    .mmc_clk(mmc_clk),
    .mmc_cmd_o(mmc_cmd_o),
    .mmc_cmd_oe(mmc_cmd_oe),
    .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [3];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [47:0] exp, input int mid_bit,
                           input bit kick_done, input int abort_bit);
    logic [47:0] rx;
    int          nb, first_k, t_done;
    logic        pclk;
    bit          aborted, quiet;
    rx = '0; nb = 0; first_k = -1; t_done = -1; aborted = 0;
    @(negedge clk);
    cmd_index = idx;
    cmd_arg   = arg;
    start     = 1'b1;
    pclk      = mmc_clk;
    for (int k = 1; k <= (48 + NCC + 4) * CLK_DIV + 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) chk("busy_rise", {63'd0, busy}, 64'd1);
      if (mmc_cmd_oe && first_k < 0) first_k = k;
      if (mmc_clk && !pclk && mmc_cmd_oe) begin
        rx = {rx[46:0], mmc_cmd_o};
        nb++;
        if (nb == mid_bit) begin
          cmd_index = ~idx;
          cmd_arg   = ~arg;
          start     = 1'b1;
        end
        if (nb == abort_bit) begin
          reset_i = 1'b1;
          #1;
          chk("abort_mmc_clk", {63'd0, mmc_clk}, 64'd0);
          chk("abort_cmd", {63'd0, mmc_cmd_o}, 64'd1);
          chk("abort_oe", {63'd0, mmc_cmd_oe}, 64'd0);
          chk("abort_busy", {63'd0, busy}, 64'd0);
          chk("abort_frame", {16'd0, frame_o}, 64'd0);
          @(negedge clk);
          reset_i = 1'b0;
          aborted = 1;
          break;
        end
      end
      pclk = mmc_clk;
      if (done) begin
        t_done = k;
        if (kick_done) start = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      chk("done_seen", {63'd0, t_done > 0}, 64'd1);
      chk("latency_ok",
          {63'd0, first_k >= 2 && first_k <= CLK_DIV + 1}, 64'd1);
      chk("bit_count", 64'(nb), 64'd48);
      chk("serial_frame", {16'd0, rx}, {16'd0, exp});
      chk("frame_o", {16'd0, frame_o}, {16'd0, exp});
      chk("occupancy", 64'(t_done - first_k), 64'((48 + NCC) * CLK_DIV));
      quiet = 1;
      for (int k = 0; k < 3 * CLK_DIV; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (done || busy || mmc_cmd_oe || !mmc_cmd_o) quiet = 0;
      end
      chk("post_quiet", {63'd0, quiet}, 64'd1);
    end
  endtask

  initial begin
    int   rises [$];
    logic pc;
    bit   quiet;
    vecs[0] = '{6'd0,  32'h0,        48'h400000000095};
    vecs[1] = '{6'd17, 32'h0,        48'h510000000055};
    vecs[2] = '{6'd8,  32'h000001AA, 48'h48000001AA87};

    reset_i   = 1'b1;
    start     = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    repeat (3) @(negedge clk);
    chk("rst_mmc_clk", {63'd0, mmc_clk}, 64'd0);
    chk("rst_cmd", {63'd0, mmc_cmd_o}, 64'd1);
    chk("rst_oe", {63'd0, mmc_cmd_oe}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_frame", {16'd0, frame_o}, 64'd0);
    reset_i = 1'b0;

    quiet = 1;
    pc = mmc_clk;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mmc_clk && !pc) rises.push_back(k);
      if (mmc_cmd_oe || !mmc_cmd_o || busy) quiet = 0;
      pc = mmc_clk;
    end
    chk("idle_quiet", {63'd0, quiet}, 64'd1);
    if (rises.size() >= 3)
      chk("idle_period", 64'(rises[2] - rises[1]), 64'(CLK_DIV));
    else
      chk("idle_rises", 64'(rises.size()), 64'd3);

    for (int i = 0; i < 3; i++)
      run_frame(vecs[i].idx, vecs[i].arg, vecs[i].exp, 0, 0, 0);

    run_frame(vecs[1].idx, vecs[1].arg, vecs[1].exp, 20, 1, 0);

    run_frame(vecs[2].idx, vecs[2].arg, vecs[2].exp, 0, 0, 30);
    run_frame(vecs[2].idx, vecs[2].arg, vecs[2].exp, 0, 0, 0);

`ifdef MMC_CMD_TX_CRC_INJECT_EN
    crc_xor = 7'h01;
    run_frame(6'd0, 32'h0, 48'h400000000097, 0, 0, 0);
    crc_xor = 7'h00;
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
